// File: rtl/pixel_plotter.sv
// Pixel-write sink: queues draw-FSM pixels in a small FIFO, drops off-screen or overflow writes,
// and drives the framebuffer write port; also runs a full-screen clear sweep on request.
module pixel_plotter #(
  parameter int unsigned         WIDTH      = 320,
  parameter int unsigned         HEIGHT     = 240,
  parameter int unsigned         COLOR_W    = 12,
  parameter int unsigned         FIFO_DEPTH = 8,
  parameter int unsigned         ADDR_W     = 17,
  parameter logic [COLOR_W-1:0]  BG_COLOR   = '0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [8:0]         inX,
  input  logic [7:0]         inY,
  input  logic [COLOR_W-1:0] inColor,
  input  logic               writeEn,
  input  logic               clear_req,
  output logic               fifo_full,
  output logic               busy,
  output logic               clear_done,
  output logic [15:0]        drop_count,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we
);

  localparam int unsigned        PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned        CntW     = PtrW + 1;
  localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0]  WidthA   = ADDR_W'(WIDTH);
  localparam logic [CntW-1:0]    DepthC   = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              stage_valid_q;
  entry_t            stage_q;
  logic              sweep_end_q, clear_done_q;
  logic [15:0]       drop_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [COLOR_W-1:0] fb_data_q;
  logic              fb_we_q;

  logic   on_screen, push, pop, drop, sweep_end;
  entry_t push_entry;

  always_comb begin
    on_screen        = (32'(inX) < WIDTH) && (32'(inY) < HEIGHT);
    // Full check uses the registered count only: a same-cycle pop never frees a slot.
    push             = writeEn && on_screen && (count_q != DepthC);
    drop             = writeEn && !push;
    push_entry.addr  = ADDR_W'(inY) * WidthA + ADDR_W'(inX);
    push_entry.color = inColor;

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pop       = 1'b0;
    sweep_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end else if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      StClear: begin
        if (clr_cnt_q == LastAddr) begin
          state_d   = StIdle;
          sweep_end = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= StIdle;
      clr_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      sweep_end_q   <= 1'b0;
      clear_done_q  <= 1'b0;
      drop_q        <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_q + CntW'(push) - CntW'(pop);
      stage_valid_q <= pop;
      if (pop) stage_q <= mem_q[rd_ptr_q];
      sweep_end_q   <= sweep_end;
      clear_done_q  <= sweep_end_q;
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (state_q == StClear) begin
        fb_we_q   <= 1'b1;
        fb_addr_q <= clr_cnt_q;
        fb_data_q <= BG_COLOR;
      end else if (stage_valid_q) begin
        fb_we_q   <= 1'b1;
        fb_addr_q <= stage_q.addr;
        fb_data_q <= stage_q.color;
      end else begin
        fb_we_q   <= 1'b0;
      end
    end
  end

  assign fifo_full  = (count_q == DepthC);
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign clear_done = clear_done_q;
  assign drop_count = drop_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign fb_we      = fb_we_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Scoreboard bench for pixel_plotter: stimulus queues expected framebuffer writes,
// a negedge monitor pops and compares every fb_we cycle.
module tb_pixel_plotter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  inX = '0;
  logic [7:0]  inY = '0;
  logic [11:0] inColor = '0;
  logic        writeEn = 1'b0;
  logic        clear_req = 1'b0;
  logic        fifo_full, busy, clear_done, fb_we;
  logic [15:0] drop_count;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;

  pixel_plotter dut (
    .clock      (clock),
    .resetn     (resetn),
    .inX        (inX),
    .inY        (inY),
    .inColor    (inColor),
    .writeEn    (writeEn),
    .clear_req  (clear_req),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .clear_done (clear_done),
    .drop_count (drop_count),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   done_pulses = 0;
  bit   mon_en = 1'b0;
  bit   full_seen = 1'b0;
  bit   last_clear_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input int a, input int d);
    exp_t x;
    x.addr = a;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic pix(input int x, input int y, input int c);
    inX     = 9'(x);
    inY     = 8'(y);
    inColor = 12'(c);
    writeEn = 1'b1;
    tick();
    writeEn = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fb_we"}, fb_we, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_fb_data"}, fb_data, 0);
    check({tag, "_clear_done"}, clear_done, 0);
    check({tag, "_drop_count"}, drop_count, 0);
    check({tag, "_fifo_full"}, fifo_full, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: every framebuffer write must match the head of the scoreboard.
  always @(negedge clock) begin
    if (mon_en) begin
      if (fifo_full) full_seen = 1'b1;
      if (clear_done) done_pulses++;
      if (last_clear_prev) check("clear_done_after_sweep", clear_done, 1);
      last_clear_prev = fb_we && (fb_addr == 17'd76799) && (fb_data == 12'h000);
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fb_we_addr", fb_addr, -1);
        end else begin
          e = exp_q.pop_front();
          check("fb_addr", fb_addr, e.addr);
          check("fb_data", fb_data, e.data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    resetn = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    mon_en = 1'b1;

    // T1: single pixel, two-clock latency
    expect_wr(6410, 'hBBB);
    pix(10, 20, 'hBBB);
    tick();
    check("t1_we_early", fb_we, 0);
    tick();
    check("t1_we_on_time", fb_we, 1);
    tick();
    check("t1_we_single", fb_we, 0);
    check("t1_busy", busy, 0);

    // T2: off-screen drops, then the bottom-right corner
    pix(320, 5, 'h111);
    pix(5, 240, 'h222);
    expect_wr(76799, 'h5A5);
    pix(319, 239, 'h5A5);
    repeat (4) tick();
    check("t2_drop_count", drop_count, 2);
    check("t2_drained", exp_q.size(), 0);

    // T3: 256 back-to-back pixels
    full_seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      expect_wr(i, (i * 7) & 'hFFF);
      pix(i, 0, (i * 7) & 'hFFF);
    end
    repeat (4) tick();
    check("t3_fifo_full_seen", full_seen, 0);
    check("t3_drop_count", drop_count, 2);
    check("t3_drained", exp_q.size(), 0);

    // T4/T5: clear sweep with 20 pixels arriving during it
    for (int a = 0; a < 76800; a++) expect_wr(a, 0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k < 8) expect_wr(100 * 320 + k * 3 + 1, 'h300 + k);
      pix(k * 3 + 1, 100, 'h300 + k);
    end
    for (int n = 0; n < 80000 && !clear_done; n++) tick();
    check("t4_clear_done_seen", clear_done, 1);
    check("t5_drop_count", drop_count, 14);
    check("t5_busy_queued", busy, 1);
    tick();
    check("t4_clear_done_pulse", clear_done, 0);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    tick();
    check("t5_drained", exp_q.size(), 0);
    check("t4_busy_idle", busy, 0);
    check("t4_done_pulses", done_pulses, 1);

    // T6: reset at clr_cnt=1000 with three pixels queued
    for (int a = 0; a < 1000; a++) expect_wr(a, 0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 3; k++) pix(200 + k, 50, 'hABC);
    repeat (997) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_reset_outputs("t6");
    check("t6_sweep_written", exp_q.size(), 0);
    repeat (20) tick();
    check("t6_no_we", fb_we, 0);
    check("t6_busy", busy, 0);
    check("t6_no_clear_done", done_pulses, 1);
    check("t6_drop_count", drop_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
